// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one asynchronous SRAM between an instruction-fetch port (IFU) and a
// load/store port (LSU). Arbitration happens only while idle; the granted
// request is latched and then played onto the SRAM pins as a strobed read or
// a three-phase (setup / pulse / hold) write. Completion is signalled by a
// one-cycle resp pulse on the granted port.
//
// Parameters
//   WAIT_CYCLES   extra access-strobe cycles beyond one (0..7)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ifu_*_i / lsu_*_i           request, we_n (0 = write), byte address,
//                               active-low byte enables, write data
//   ifu_rdata_o / lsu_rdata_o   last read data returned to that port
//   ifu_resp_o / lsu_resp_o     one-cycle completion pulse
//   ram_*                       registered SRAM pins, strobes active-low;
//                               ram_addr_o is a word address (addr[21:2])
//   busy_o                      high whenever an access is in progress
// ---------------------------------------------------------------------------
module sram_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ifu_req_i,
   input  logic        ifu_we_n_i,
   input  logic [31:0] ifu_addr_i,
   input  logic [3:0]  ifu_be_n_i,
   input  logic [31:0] ifu_wdata_i,
   output logic [31:0] ifu_rdata_o,
   output logic        ifu_resp_o,
   input  logic        lsu_req_i,
   input  logic        lsu_we_n_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [3:0]  lsu_be_n_i,
   input  logic [31:0] lsu_wdata_i,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_resp_o,
   output logic [19:0] ram_addr_o,
   output logic [31:0] ram_wdata_o,
   input  logic [31:0] ram_rdata_i,
   output logic [3:0]  ram_be_n_o,
   output logic        ram_ce_n_o,
   output logic        ram_oe_n_o,
   output logic        ram_we_n_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WSETUP,
      WPULSE,
      WHOLD,
      DONE
   } state_e;

   typedef enum logic {
      SEL_IFU = 1'b0,
      SEL_LSU = 1'b1
   } sel_e;

   localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

   state_e      state_q;
   sel_e        gnt_q;
   sel_e        last_grant_q;
   logic [2:0]  cnt_q;
   logic [19:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_n_q;
   logic        ce_n_q;
   logic        oe_n_q;
   logic        we_n_q;
   logic [31:0] ifu_rdata_q;
   logic [31:0] lsu_rdata_q;
   logic        ifu_resp_q;
   logic        lsu_resp_q;

   // Arbitration result for the current cycle; only consumed in IDLE.
   sel_e        sel_d;
   logic        sel_we_n_d;
   logic [19:0] sel_addr_d;
   logic [3:0]  sel_be_n_d;
   logic [31:0] sel_wdata_d;

   // Byte-offset and upper address bits lie outside the SRAM word window.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^{ifu_addr_i[31:22], ifu_addr_i[1:0],
                               lsu_addr_i[31:22], lsu_addr_i[1:0]};

   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      // Contention: hand the SRAM to whichever port did not have it last.
      sel_d = (last_grant_q == SEL_IFU) ? SEL_LSU : SEL_IFU;
      if (ifu_req_i && !lsu_req_i) begin
         sel_d = SEL_IFU;
      end else if (lsu_req_i && !ifu_req_i) begin
         sel_d = SEL_LSU;
      end
   end

   assign sel_we_n_d  = (sel_d == SEL_LSU) ? lsu_we_n_i        : ifu_we_n_i;
   assign sel_addr_d  = (sel_d == SEL_LSU) ? lsu_addr_i[21:2]  : ifu_addr_i[21:2];
   assign sel_be_n_d  = (sel_d == SEL_LSU) ? lsu_be_n_i        : ifu_be_n_i;
   assign sel_wdata_d = (sel_d == SEL_LSU) ? lsu_wdata_i       : ifu_wdata_i;

   // Outputs are loaded on the same edge that enters a state, so the pins
   // always show the values that belong to the current state. Direction is
   // carried by the state itself (RD vs. W*), so no separate we_n copy is kept.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         gnt_q        <= SEL_IFU;
         last_grant_q <= SEL_IFU;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_n_q       <= 4'hF;
         ce_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         ifu_rdata_q  <= '0;
         lsu_rdata_q  <= '0;
         ifu_resp_q   <= 1'b0;
         lsu_resp_q   <= 1'b0;
      end else begin
         // resp is a pulse: cleared every cycle unless DONE is being entered.
         ifu_resp_q <= 1'b0;
         lsu_resp_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (ifu_req_i || lsu_req_i) begin
                  gnt_q        <= sel_d;
                  last_grant_q <= sel_d;
                  addr_q       <= sel_addr_d;
                  be_n_q       <= sel_be_n_d;
                  wdata_q      <= sel_wdata_d;
                  ce_n_q       <= 1'b0;
                  if (sel_we_n_d) begin
                     state_q <= RD;
                     oe_n_q  <= 1'b0;
                     cnt_q   <= WAIT_LD;
                  end else begin
                     state_q <= WSETUP;
                  end
               end
            end

            RD: begin
               if (cnt_q == 3'd0) begin
                  // Last strobe cycle: data is valid on the pins now.
                  if (gnt_q == SEL_LSU) begin
                     lsu_rdata_q <= ram_rdata_i;
                     lsu_resp_q  <= 1'b1;
                  end else begin
                     ifu_rdata_q <= ram_rdata_i;
                     ifu_resp_q  <= 1'b1;
                  end
                  state_q <= DONE;
                  ce_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  be_n_q  <= 4'hF;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end

            WSETUP: begin
               state_q <= WPULSE;
               we_n_q  <= 1'b0;
               cnt_q   <= WAIT_LD;
            end

            WPULSE: begin
               if (cnt_q == 3'd0) begin
                  state_q <= WHOLD;
                  we_n_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end

            WHOLD: begin
               state_q <= DONE;
               ce_n_q  <= 1'b1;
               be_n_q  <= 4'hF;
               if (gnt_q == SEL_LSU) begin
                  lsu_resp_q <= 1'b1;
               end else begin
                  ifu_resp_q <= 1'b1;
               end
            end

            DONE: begin
               // Always return to IDLE so a held request is re-arbitrated.
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
               ce_n_q  <= 1'b1;
               oe_n_q  <= 1'b1;
               we_n_q  <= 1'b1;
               be_n_q  <= 4'hF;
            end
         endcase
      end
   end

   assign ram_addr_o  = addr_q;
   assign ram_wdata_o = wdata_q;
   assign ram_be_n_o  = be_n_q;
   assign ram_ce_n_o  = ce_n_q;
   assign ram_oe_n_o  = oe_n_q;
   assign ram_we_n_o  = we_n_q;
   assign ifu_rdata_o = ifu_rdata_q;
   assign lsu_rdata_o = lsu_rdata_q;
   assign ifu_resp_o  = ifu_resp_q;
   assign lsu_resp_o  = lsu_resp_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//
// Two arbiters share a clock and reset: index 0 built with WAIT_CYCLES=1,
// index 1 with WAIT_CYCLES=0. Each has its own word-wide SRAM model. The
// expected pin timing, grant order and read data come from a transaction
// level model: a reference memory updated per issued write, a last-grant
// bit per arbiter, and per-cycle strobe masks derived from the access
// latencies.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

   localparam int W0 = 1;
   localparam int W1 = 0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        ifu_req [2];
   logic        ifu_we_n [2];
   logic [31:0] ifu_addr [2];
   logic [3:0]  ifu_be_n [2];
   logic [31:0] ifu_wdata [2];
   logic [31:0] ifu_rdata [2];
   logic        ifu_resp [2];
   logic        lsu_req [2];
   logic        lsu_we_n [2];
   logic [31:0] lsu_addr [2];
   logic [3:0]  lsu_be_n [2];
   logic [31:0] lsu_wdata [2];
   logic [31:0] lsu_rdata [2];
   logic        lsu_resp [2];
   logic [19:0] ram_addr [2];
   logic [31:0] ram_wdata [2];
   logic [31:0] ram_rdata [2];
   logic [3:0]  ram_be_n [2];
   logic        ram_ce_n [2];
   logic        ram_oe_n [2];
   logic        ram_we_n [2];
   logic        busy [2];

   sram_arbiter #(.WAIT_CYCLES(W0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_i(ifu_req[0]), .ifu_we_n_i(ifu_we_n[0]), .ifu_addr_i(ifu_addr[0]),
      .ifu_be_n_i(ifu_be_n[0]), .ifu_wdata_i(ifu_wdata[0]),
      .ifu_rdata_o(ifu_rdata[0]), .ifu_resp_o(ifu_resp[0]),
      .lsu_req_i(lsu_req[0]), .lsu_we_n_i(lsu_we_n[0]), .lsu_addr_i(lsu_addr[0]),
      .lsu_be_n_i(lsu_be_n[0]), .lsu_wdata_i(lsu_wdata[0]),
      .lsu_rdata_o(lsu_rdata[0]), .lsu_resp_o(lsu_resp[0]),
      .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]), .ram_rdata_i(ram_rdata[0]),
      .ram_be_n_o(ram_be_n[0]), .ram_ce_n_o(ram_ce_n[0]), .ram_oe_n_o(ram_oe_n[0]),
      .ram_we_n_o(ram_we_n[0]), .busy_o(busy[0])
   );

   sram_arbiter #(.WAIT_CYCLES(W1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_i(ifu_req[1]), .ifu_we_n_i(ifu_we_n[1]), .ifu_addr_i(ifu_addr[1]),
      .ifu_be_n_i(ifu_be_n[1]), .ifu_wdata_i(ifu_wdata[1]),
      .ifu_rdata_o(ifu_rdata[1]), .ifu_resp_o(ifu_resp[1]),
      .lsu_req_i(lsu_req[1]), .lsu_we_n_i(lsu_we_n[1]), .lsu_addr_i(lsu_addr[1]),
      .lsu_be_n_i(lsu_be_n[1]), .lsu_wdata_i(lsu_wdata[1]),
      .lsu_rdata_o(lsu_rdata[1]), .lsu_resp_o(lsu_resp[1]),
      .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]), .ram_rdata_i(ram_rdata[1]),
      .ram_be_n_o(ram_be_n[1]), .ram_ce_n_o(ram_ce_n[1]), .ram_oe_n_o(ram_oe_n[1]),
      .ram_we_n_o(ram_we_n[1]), .busy_o(busy[1])
   );

   // SRAM models: asynchronous read, byte writes committed at each clock
   // edge that sees the write strobe low.
   logic [31:0] sram_m [2][16];
   assign ram_rdata[0] = sram_m[0][ram_addr[0][3:0]];
   assign ram_rdata[1] = sram_m[1][ram_addr[1][3:0]];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (ram_ce_n[d] === 1'b0 && ram_we_n[d] === 1'b0) begin
            for (int b = 0; b < 4; b++) begin
               if (!ram_be_n[d][b]) sram_m[d][ram_addr[d][3:0]][b*8 +: 8] = ram_wdata[d][b*8 +: 8];
            end
         end
      end
   end

   // Transaction-level reference state.
   logic [31:0] ref_mem [2][16];
   logic [31:0] ref_rdata [2][2];   // [arbiter][0 = IFU, 1 = LSU]
   bit          last_lsu [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int wait_of(input int d);
      return (d == 0) ? W0 : W1;
   endfunction

   function automatic logic [31:0] span(input int lo, input int hi);
      logic [31:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be_n);
      for (int b = 0; b < 4; b++) if (!be_n[b]) old[b*8 +: 8] = nw[b*8 +: 8];
      return old;
   endfunction

   function automatic logic resp_of(input int d, input bit p);
      return p ? lsu_resp[d] : ifu_resp[d];
   endfunction

   function automatic logic [31:0] rdata_of(input int d, input bit p);
      return p ? lsu_rdata[d] : ifu_rdata[d];
   endfunction

   task automatic drive(input int d, input bit p, input logic req, input logic we_n,
                        input logic [31:0] addr, input logic [3:0] be_n, input logic [31:0] wdata);
      if (p) begin
         lsu_req[d] = req; lsu_we_n[d] = we_n; lsu_addr[d] = addr;
         lsu_be_n[d] = be_n; lsu_wdata[d] = wdata;
      end else begin
         ifu_req[d] = req; ifu_we_n[d] = we_n; ifu_addr[d] = addr;
         ifu_be_n[d] = be_n; ifu_wdata[d] = wdata;
      end
   endtask

   // One access from a single requester. The request is dropped and the
   // request fields scrambled right after the grant edge; the access must
   // still run to completion with the latched values.
   task automatic do_access(input int d, input bit p, input logic we_n, input logic [31:0] addr,
                            input logic [3:0] be_n, input logic [31:0] wdata);
      int          w;
      int          lat;
      int          addr_bad;
      int          be_bad;
      int          wd_bad;
      bit          q;
      logic [3:0]  idx;
      logic [31:0] ce_m, oe_m, we_m, rsp_m, oth_m, bsy_m, both_m;
      w = wait_of(d);
      lat = we_n ? w + 2 : w + 4;
      q = ~p;
      idx = addr[5:2];
      addr_bad = 0; be_bad = 0; wd_bad = 0;
      ce_m = '0; oe_m = '0; we_m = '0; rsp_m = '0; oth_m = '0; bsy_m = '0; both_m = '0;
      if (we_n) ref_rdata[d][p] = ref_mem[d][idx];
      else      ref_mem[d][idx] = merge(ref_mem[d][idx], wdata, be_n);

      @(negedge clk);
      drive(d, p, 1'b1, we_n, addr, be_n, wdata);
      @(posedge clk); #1;
      drive(d, p, 1'b0, 1'($urandom()), $urandom(), 4'($urandom()), $urandom());
      for (int c = 1; c <= lat + 1; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         if (!ram_ce_n[d]) begin
            ce_m[c] = 1'b1;
            if (ram_addr[d] !== addr[21:2]) addr_bad++;
            if (ram_be_n[d] !== be_n) be_bad++;
         end
         if (!ram_oe_n[d]) oe_m[c] = 1'b1;
         if (!ram_we_n[d]) we_m[c] = 1'b1;
         if (!ram_oe_n[d] && !ram_we_n[d]) both_m[c] = 1'b1;
         if (!we_n && c <= w + 3 && ram_wdata[d] !== wdata) wd_bad++;
         if (resp_of(d, p)) rsp_m[c] = 1'b1;
         if (resp_of(d, q)) oth_m[c] = 1'b1;
         if (busy[d]) bsy_m[c] = 1'b1;
         if (c == lat) begin
            check("done_be_n", ram_be_n[d], 4'hF);
            check("granted_rdata", rdata_of(d, p), ref_rdata[d][p]);
            check("other_rdata", rdata_of(d, q), ref_rdata[d][q]);
         end
      end
      check("ce_n_low_cycles", ce_m, we_n ? span(1, w + 1) : span(1, w + 3));
      check("oe_n_low_cycles", oe_m, we_n ? span(1, w + 1) : 32'h0);
      check("we_n_low_cycles", we_m, we_n ? 32'h0 : span(2, w + 2));
      check("resp_cycle", rsp_m, span(lat, lat));
      check("other_resp", oth_m, 32'h0);
      check("busy_cycles", bsy_m, span(1, lat));
      check("oe_we_overlap", both_m, 32'h0);
      check("addr_stable", addr_bad, 0);
      check("be_n_stable", be_bad, 0);
      check("wdata_stable", wd_bad, 0);
      last_lsu[d] = p;
   endtask

   // Both ports request reads continuously; grants must alternate starting
   // with the port that did not win last.
   task automatic contend(input int d, input int n, input logic [3:0] ia, input logic [3:0] la);
      bit          exp_lsu;
      int          got;
      int          overlap;
      int          order_bad;
      logic [31:0] aa, ab;
      exp_lsu = !last_lsu[d];
      got = 0; overlap = 0; order_bad = 0;
      aa = $urandom(); aa[5:2] = ia;
      ab = $urandom(); ab[5:2] = la;
      ref_rdata[d][0] = ref_mem[d][ia];
      ref_rdata[d][1] = ref_mem[d][la];
      @(negedge clk);
      drive(d, 1'b0, 1'b1, 1'b1, aa, 4'h0, 32'h0);
      drive(d, 1'b1, 1'b1, 1'b1, ab, 4'h0, 32'h0);
      for (int c = 0; c < 80 && got < n; c++) begin
         @(posedge clk); #1;
         if (ifu_resp[d] && lsu_resp[d]) overlap++;
         if (ifu_resp[d] || lsu_resp[d]) begin
            if (lsu_resp[d] !== exp_lsu) order_bad++;
            last_lsu[d] = exp_lsu;
            exp_lsu = !exp_lsu;
            got++;
            if (got == n) begin
               drive(d, 1'b0, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0);
               drive(d, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0);
            end
         end
      end
      check("contend_resp_count", got, n);
      check("contend_overlap", overlap, 0);
      check("contend_order", order_bad, 0);
      check("contend_ifu_rdata", ifu_rdata[d], ref_rdata[d][0]);
      check("contend_lsu_rdata", lsu_rdata[d], ref_rdata[d][1]);
      for (int c = 0; c < 4 && busy[d]; c++) begin @(posedge clk); #1; end
      check("contend_idle", busy[d], 1'b0);
      drive(d, 1'b0, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0);
      drive(d, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0);
   endtask

   task automatic check_reset_outputs(input int d);
      check("rst_busy", busy[d], 1'b0);
      check("rst_ce_n", ram_ce_n[d], 1'b1);
      check("rst_oe_n", ram_oe_n[d], 1'b1);
      check("rst_we_n", ram_we_n[d], 1'b1);
      check("rst_be_n", ram_be_n[d], 4'hF);
      check("rst_addr", ram_addr[d], 20'h0);
      check("rst_wdata", ram_wdata[d], 32'h0);
      check("rst_ifu_resp", ifu_resp[d], 1'b0);
      check("rst_lsu_resp", lsu_resp[d], 1'b0);
      check("rst_ifu_rdata", ifu_rdata[d], 32'h0);
      check("rst_lsu_rdata", lsu_rdata[d], 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, rsp_l, rsp_i, quiet;
      rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         drive(d, 1'b0, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0);
         drive(d, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0);
         last_lsu[d] = 1'b0;
         for (int p = 0; p < 2; p++) ref_rdata[d][p] = 32'h0;
         for (int i = 0; i < 16; i++) begin
            sram_m[d][i] = $urandom();
            ref_mem[d][i] = sram_m[d][i];
         end
      end

      // Reset state.
      #2 rst_n = 1'b0;
      #10;
      check_reset_outputs(0);
      check_reset_outputs(1);
      @(negedge clk) rst_n = 1'b1;

      // Continuous contention from reset: LSU, IFU, LSU, IFU.
      contend(0, 4, 4'd1, 4'd2);
      contend(1, 4, 4'd3, 4'd4);

      // Directed IFU read and LSU write on the WAIT_CYCLES=1 arbiter.
      sram_m[0][4] = 32'h1234_5678;
      ref_mem[0][4] = 32'h1234_5678;
      do_access(0, 1'b0, 1'b1, 32'h8000_0010, 4'h0, 32'h0);
      check("directed_read_data", ifu_rdata[0], 32'h1234_5678);
      do_access(0, 1'b1, 1'b0, 32'h8000_0008, 4'b1100, 32'hCAFE_F00D);

      // Single-cycle strobe build: read and write.
      do_access(1, 1'b0, 1'b1, 32'h0000_0014, 4'h0, 32'h0);
      do_access(1, 1'b1, 1'b0, 32'h0000_0018, 4'b0000, 32'hA5A5_5A5A);
      do_access(1, 1'b1, 1'b1, 32'h0000_0018, 4'h0, 32'h0);

      // LSU write released mid-pulse while the IFU queues behind it.
      a = 32'h8000_0024;
      ref_mem[0][9] = merge(ref_mem[0][9], 32'h1122_3344, 4'b0011);
      ref_rdata[0][0] = ref_mem[0][9];
      rsp_l = '0; rsp_i = '0;
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 1'b0, a, 4'b0011, 32'h1122_3344);
      @(posedge clk); #1;
      for (int c = 2; c <= W0 + 4 + 1 + W0 + 2 + 1; c++) begin
         @(posedge clk); #1;
         if (c == 2) begin
            drive(0, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0);
            drive(0, 1'b0, 1'b1, 1'b1, a, 4'h0, 32'h0);
         end
         if (lsu_resp[0]) rsp_l[c] = 1'b1;
         if (ifu_resp[0]) begin
            rsp_i[c] = 1'b1;
            drive(0, 1'b0, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0);
         end
      end
      check("dropped_lsu_resp", rsp_l, span(W0 + 4, W0 + 4));
      check("queued_ifu_resp", rsp_i, span(W0 + 7 + W0 - 1 + 1, W0 + 7 + W0 - 1 + 1));
      check("queued_ifu_rdata", ifu_rdata[0], ref_rdata[0][0]);
      last_lsu[0] = 1'b0;

      // Randomised single-requester traffic on both builds.
      for (int n = 0; n < 36; n++) begin
         int          d;
         bit          p;
         logic        wn;
         logic [31:0] ad;
         d = (n < 24) ? 0 : 1;
         p = 1'($urandom());
         wn = 1'($urandom());
         ad = $urandom();
         repeat ($urandom_range(0, 2)) @(posedge clk);
         do_access(d, p, wn, ad, 4'($urandom()), $urandom());
      end

      // Contention after mixed history: winner follows the last single grant.
      contend(0, 2, 4'd6, 4'd7);
      contend(1, 2, 4'd8, 4'd10);

      // Asynchronous reset in the middle of a write pulse.
      a = $urandom();
      a[5:2] = 4'd3;
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 1'b0, a, 4'h0, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0);
      @(posedge clk); #1;
      check("pre_rst_we_n", ram_we_n[0], 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs(0);
      check_reset_outputs(1);
      for (int d = 0; d < 2; d++) begin
         last_lsu[d] = 1'b0;
         for (int p = 0; p < 2; p++) ref_rdata[d][p] = 32'h0;
      end
      @(negedge clk) rst_n = 1'b1;
      quiet = '0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (busy[0] || ifu_resp[0] || lsu_resp[0]) quiet[c] = 1'b1;
      end
      check("post_rst_quiet", quiet, 32'h0);
      contend(0, 2, 4'd3, 4'd11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1 (legal 0..7): extra access-strobe cycles beyond one.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports ifu_req_i in 1, ifu_we_n_i in 1, ifu_addr_i in 32, ifu_be_n_i in 4, ifu_wdata_i in 32: IFU request; we_n=0 write, 1 read; be_n active-low.
REQ-005 SHALL have ports ifu_rdata_o out 32, ifu_resp_o out 1: IFU read data, completion pulse.
REQ-006 SHALL have ports lsu_req_i, lsu_we_n_i, lsu_addr_i, lsu_be_n_i, lsu_wdata_i, lsu_rdata_o, lsu_resp_o: same widths and meaning as IFU set.
REQ-007 SHALL have ports ram_addr_o out 20, ram_wdata_o out 32, ram_rdata_i in 32, ram_be_n_o out 4, ram_ce_n_o out 1, ram_oe_n_o out 1, ram_we_n_o out 1: shared SRAM pins, strobes active-low.
REQ-008 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL implement states IDLE, RD, WSETUP, WPULSE, WHOLD, DONE.
REQ-010 SHALL arbitrate only in IDLE; with one requester, grant it; with both, grant the one not granted last (last_grant register).
REQ-011 SHALL latch granted addr, be_n, wdata, we_n into internal registers at grant; later input changes SHALL NOT affect the access.
REQ-012 SHALL drive ram_addr_o = latched addr[21:2]; ram_be_n_o = latched be_n while ce_n is low.
REQ-013 Read: IDLE->RD; RD holds ce_n=0, oe_n=0, we_n=1 for WAIT_CYCLES+1 cycles (3-bit counter); rdata captured from ram_rdata_i on last RD cycle; then DONE.
REQ-014 Write: IDLE->WSETUP (1 cycle, ce_n=0, we_n=1, oe_n=1, data driven)->WPULSE (WAIT_CYCLES+1 cycles, we_n=0)->WHOLD (1 cycle, we_n=1, ce_n=0, addr/data held)->DONE.
REQ-015 All ram_* outputs SHALL be registered; wdata SHALL stay stable from WSETUP through WHOLD.
REQ-016 In DONE: ce_n=oe_n=we_n=1, be_n=4'hF, granted requester's resp_o=1 for exactly one cycle, its rdata_o = captured data (reads); next state IDLE.
REQ-017 rdata_o SHALL hold last captured value until next read completion for that requester; ungranted requester's resp_o SHALL stay 0.
REQ-018 Latency from req sampled in IDLE (cycle 0) to resp_o: read WAIT_CYCLES+2 cycles after; write WAIT_CYCLES+4 cycles after.
REQ-019 Requester SHALL hold req high until resp_o; req deasserted mid-access SHALL NOT abort; access completes and resp_o still pulses.
REQ-020 A requester holding req after its resp_o SHALL be treated as new request in following IDLE cycle (no back-to-back grant from DONE).
REQ-021 ce_n, oe_n, we_n SHALL never be simultaneously with oe_n=0 and we_n=0.
REQ-022 Counter SHALL reload to WAIT_CYCLES on entry to RD/WPULSE and decrement to 0; WAIT_CYCLES=0 gives single-cycle strobe.

Reset
REQ-023 On rst_n=0 (asynchronous, any state incl. mid-write) SHALL force: state=IDLE, ram_ce_n_o=ram_oe_n_o=ram_we_n_o=1, ram_be_n_o=4'hF, ram_addr_o=0, ram_wdata_o=0, both resp_o=0, both rdata_o=0, busy_o=0, counter=0, last_grant=IFU (LSU wins first contention).
REQ-024 After rst_n rises, first arbitration SHALL occur on first clock edge in IDLE; no partial access resumes.

Verification (WAIT_CYCLES=1)
REQ-025 IFU read addr 0x8000_0010, ram_rdata_i=0x1234_5678 -> ram_addr_o=0x00004, oe_n low 2 cycles, ifu_resp_o pulse at cycle 3, ifu_rdata_o=0x1234_5678.
REQ-026 LSU write addr 0x8000_0008, wdata 0xCAFE_F00D, be_n 4'b1100 -> we_n low exactly cycles 2-3, ce_n low cycles 1-4, lsu_resp_o at cycle 5, be_n_o=4'b1100.
REQ-027 Both req asserted from reset, held continuously -> grants alternate LSU, IFU, LSU, IFU; never two resp_o in same cycle.
REQ-028 LSU drops req during WPULSE -> write still completes, lsu_resp_o pulses once, ifu waiting granted next IDLE.
REQ-029 rst_n asserted during WPULSE -> we_n_o, ce_n_o go 1 without clock edge; busy_o=0; no resp_o after release.
REQ-030 WAIT_CYCLES=0 build, IFU read -> oe_n low 1 cycle, resp at cycle 2; write resp at cycle 4.
